// File: rtl/encoder_pkg.sv
// Shared encoder definitions used by the tracker and the SPI reader.
package encoder_pkg;

  localparam int unsigned ENC_BITS         = 13;
  localparam int unsigned DEFAULT_MAX_STEP = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CH1  = 2'd1,
    ST_CH2  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic [ENC_BITS-1:0] enc1;
    logic [ENC_BITS-1:0] enc2;
  } frame_t;

endpackage

// File: rtl/encoder_tracker_if.sv
// Frame input and tracked-position result bundle for encoder_tracker.
interface encoder_tracker_if
  import encoder_pkg::*;
#(
  parameter int unsigned TURN_BITS = 8
);

  logic                          frame_done;
  logic [ENC_BITS-1:0]           enc1_data;
  logic [ENC_BITS-1:0]           enc2_data;
  logic                          clear_faults;
  logic [TURN_BITS+ENC_BITS-1:0] enc1_pos;
  logic [TURN_BITS+ENC_BITS-1:0] enc2_pos;
  logic [ENC_BITS-1:0]           enc1_delta;
  logic [ENC_BITS-1:0]           enc2_delta;
  logic                          pos_valid;
  logic                          enc1_fault;
  logic                          enc2_fault;
  logic                          overrun;
  logic                          busy;

  modport master (
    output frame_done, enc1_data, enc2_data, clear_faults,
    input  enc1_pos, enc2_pos, enc1_delta, enc2_delta,
    input  pos_valid, enc1_fault, enc2_fault, overrun, busy
  );

  modport slave (
    input  frame_done, enc1_data, enc2_data, clear_faults,
    output enc1_pos, enc2_pos, enc1_delta, enc2_delta,
    output pos_valid, enc1_fault, enc2_fault, overrun, busy
  );

endinterface

// File: rtl/encoder_step_calc.sv
// Wrap-aware signed step between two single-turn readings and plausibility test.
module encoder_step_calc
  import encoder_pkg::*;
(
  input  logic [ENC_BITS-1:0]        raw,
  input  logic [ENC_BITS-1:0]        prev,
  input  logic [ENC_BITS-1:0]        max_step,
  output logic signed [ENC_BITS-1:0] d,
  output logic                       accept
);

  logic [ENC_BITS-1:0] diff;
  logic [ENC_BITS-1:0] mag;

  // Modular difference, its magnitude (-4096 maps to 4096) and the limit check.
  always_comb begin
    diff   = raw - prev;
    mag    = diff[ENC_BITS-1] ? (ENC_BITS'(0) - diff) : diff;
    d      = $signed(diff);
    accept = (mag <= max_step);
  end

endmodule

// File: rtl/encoder_tracker.sv
// Dual-channel multi-turn encoder tracker; channels share one step calculator.
module encoder_tracker
  import encoder_pkg::*;
#(
  parameter int unsigned MAX_STEP  = DEFAULT_MAX_STEP,
  parameter int unsigned TURN_BITS = 8
)(
  input  logic                          CLK_10MHZ,
  input  logic                          RESET_N,
  input  logic                          frame_done,
  input  logic [ENC_BITS-1:0]           enc1_data,
  input  logic [ENC_BITS-1:0]           enc2_data,
  input  logic                          clear_faults,
  output logic [TURN_BITS+ENC_BITS-1:0] enc1_pos,
  output logic [TURN_BITS+ENC_BITS-1:0] enc2_pos,
  output logic [ENC_BITS-1:0]           enc1_delta,
  output logic [ENC_BITS-1:0]           enc2_delta,
  output logic                          pos_valid,
  output logic                          enc1_fault,
  output logic                          enc2_fault,
  output logic                          overrun,
  output logic                          busy
);

  localparam int unsigned POS_W = TURN_BITS + ENC_BITS;

  state_e              state_q, state_d;
  frame_t              frame_q, frame_d;
  logic [ENC_BITS-1:0] prev1_q, prev1_d, prev2_q, prev2_d;
  logic [POS_W-1:0]    pos1_q, pos1_d, pos2_q, pos2_d;
  logic [ENC_BITS-1:0] delta1_q, delta1_d, delta2_q, delta2_d;
  logic                fault1_q, fault1_d, fault2_q, fault2_d;
  logic                overrun_q, overrun_d;
  logic                primed_q, primed_d;
  logic                pos_valid_q, pos_valid_d;
  logic                busy_q, busy_d;

  logic [ENC_BITS-1:0]        sel_raw, sel_prev;
  logic [POS_W-1:0]           sel_pos;
  logic signed [ENC_BITS-1:0] step_d;
  logic                       step_ok;
  logic [POS_W-1:0]           upd_pos;
  logic [ENC_BITS-1:0]        upd_prev, upd_delta;
  logic                       upd_fault;

  encoder_step_calc u_step (
    .raw      (sel_raw),
    .prev     (sel_prev),
    .max_step (ENC_BITS'(MAX_STEP)),
    .d        (step_d),
    .accept   (step_ok)
  );

  // Shared arithmetic path: select channel, then prime / accept / reject.
  always_comb begin
    sel_raw   = (state_q == ST_CH2) ? frame_q.enc2 : frame_q.enc1;
    sel_prev  = (state_q == ST_CH2) ? prev2_q : prev1_q;
    sel_pos   = (state_q == ST_CH2) ? pos2_q : pos1_q;
    upd_fault = 1'b0;
    if (!primed_q) begin
      upd_pos   = POS_W'(sel_raw);
      upd_prev  = sel_raw;
      upd_delta = '0;
    end else if (step_ok) begin
      upd_pos   = sel_pos + {{TURN_BITS{step_d[ENC_BITS-1]}}, $unsigned(step_d)};
      upd_prev  = sel_raw;
      upd_delta = $unsigned(step_d);
    end else begin
      upd_pos   = sel_pos;
      upd_prev  = sel_prev;
      upd_delta = '0;
      upd_fault = 1'b1;
    end
  end

  // Next-state sequencing, frame capture, channel updates and sticky flags.
  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    prev1_d     = prev1_q;
    prev2_d     = prev2_q;
    pos1_d      = pos1_q;
    pos2_d      = pos2_q;
    delta1_d    = delta1_q;
    delta2_d    = delta2_q;
    primed_d    = primed_q;
    fault1_d    = fault1_q & ~clear_faults;
    fault2_d    = fault2_q & ~clear_faults;
    overrun_d   = overrun_q & ~clear_faults;
    pos_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (frame_done) begin
          frame_d.enc1 = enc1_data;
          frame_d.enc2 = enc2_data;
          state_d      = ST_CH1;
        end
      end
      ST_CH1: begin
        pos1_d   = upd_pos;
        prev1_d  = upd_prev;
        delta1_d = upd_delta;
        fault1_d = fault1_d | upd_fault;
        state_d  = ST_CH2;
      end
      ST_CH2: begin
        pos2_d      = upd_pos;
        prev2_d     = upd_prev;
        delta2_d    = upd_delta;
        fault2_d    = fault2_d | upd_fault;
        primed_d    = 1'b1;
        pos_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (frame_done && (state_q != ST_IDLE)) overrun_d = 1'b1;
    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK_10MHZ) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      frame_q     <= '0;
      prev1_q     <= '0;
      prev2_q     <= '0;
      pos1_q      <= '0;
      pos2_q      <= '0;
      delta1_q    <= '0;
      delta2_q    <= '0;
      fault1_q    <= 1'b0;
      fault2_q    <= 1'b0;
      overrun_q   <= 1'b0;
      primed_q    <= 1'b0;
      pos_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      prev1_q     <= prev1_d;
      prev2_q     <= prev2_d;
      pos1_q      <= pos1_d;
      pos2_q      <= pos2_d;
      delta1_q    <= delta1_d;
      delta2_q    <= delta2_d;
      fault1_q    <= fault1_d;
      fault2_q    <= fault2_d;
      overrun_q   <= overrun_d;
      primed_q    <= primed_d;
      pos_valid_q <= pos_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign enc1_pos   = pos1_q;
  assign enc2_pos   = pos2_q;
  assign enc1_delta = delta1_q;
  assign enc2_delta = delta2_q;
  assign pos_valid  = pos_valid_q;
  assign enc1_fault = fault1_q;
  assign enc2_fault = fault2_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_encoder_tracker.sv
// Directed, table-driven bench for encoder_tracker (MAX_STEP 1024, TURN_BITS 8).
module tb_encoder_tracker;
  import encoder_pkg::*;

  localparam int unsigned TB_TURN = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #50 clk = ~clk;

  encoder_tracker_if #(.TURN_BITS(TB_TURN)) bus ();

  encoder_tracker #(.MAX_STEP(1024), .TURN_BITS(TB_TURN)) dut (
    .CLK_10MHZ    (clk),
    .RESET_N      (rst_n),
    .frame_done   (bus.frame_done),
    .enc1_data    (bus.enc1_data),
    .enc2_data    (bus.enc2_data),
    .clear_faults (bus.clear_faults),
    .enc1_pos     (bus.enc1_pos),
    .enc2_pos     (bus.enc2_pos),
    .enc1_delta   (bus.enc1_delta),
    .enc2_delta   (bus.enc2_delta),
    .pos_valid    (bus.pos_valid),
    .enc1_fault   (bus.enc1_fault),
    .enc2_fault   (bus.enc2_fault),
    .overrun      (bus.overrun),
    .busy         (bus.busy)
  );

  typedef struct {
    logic [12:0] e1, e2;
    logic [20:0] p1, p2;
    logic [12:0] d1, d2;
    logic        f1, f2;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " enc1_pos"},   32'(bus.enc1_pos),   0);
    chk({tag, " enc2_pos"},   32'(bus.enc2_pos),   0);
    chk({tag, " enc1_delta"}, 32'(bus.enc1_delta), 0);
    chk({tag, " enc2_delta"}, 32'(bus.enc2_delta), 0);
    chk({tag, " pos_valid"},  32'(bus.pos_valid),  0);
    chk({tag, " enc1_fault"}, 32'(bus.enc1_fault), 0);
    chk({tag, " enc2_fault"}, 32'(bus.enc2_fault), 0);
    chk({tag, " overrun"},    32'(bus.overrun),    0);
    chk({tag, " busy"},       32'(bus.busy),       0);
  endtask

  // Send one frame and wait (bounded) for pos_valid; returns latency in cycles.
  task automatic run_frame(input logic [12:0] e1, input logic [12:0] e2, output int lat);
    @(negedge clk);
    bus.frame_done = 1'b1;
    bus.enc1_data  = e1;
    bus.enc2_data  = e2;
    @(negedge clk);
    bus.frame_done = 1'b0;
    bus.enc1_data  = ~e1;
    bus.enc2_data  = ~e2;
    lat = 1;
    while (!bus.pos_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic apply_row(input int i);
    int lat;
    run_frame(tbl[i].e1, tbl[i].e2, lat);
    chk($sformatf("row%0d latency", i),    32'(lat),            3);
    chk($sformatf("row%0d enc1_pos", i),   32'(bus.enc1_pos),   32'(tbl[i].p1));
    chk($sformatf("row%0d enc2_pos", i),   32'(bus.enc2_pos),   32'(tbl[i].p2));
    chk($sformatf("row%0d enc1_delta", i), 32'(bus.enc1_delta), 32'(tbl[i].d1));
    chk($sformatf("row%0d enc2_delta", i), 32'(bus.enc2_delta), 32'(tbl[i].d2));
    chk($sformatf("row%0d enc1_fault", i), 32'(bus.enc1_fault), 32'(tbl[i].f1));
    chk($sformatf("row%0d enc2_fault", i), 32'(bus.enc2_fault), 32'(tbl[i].f2));
    chk($sformatf("row%0d overrun", i),    32'(bus.overrun),    0);
    @(negedge clk);
    chk($sformatf("row%0d pulse width", i), 32'(bus.pos_valid), 0);
    chk($sformatf("row%0d idle busy", i),   32'(bus.busy),      0);
  endtask

  initial begin
    int lat;
    int cnt;

    tbl[0] = '{13'd8190, 13'd100,  21'd8190,    21'd100,  13'd0,    13'd0,    1'b0, 1'b0};
    tbl[1] = '{13'd5,    13'd2000, 21'd8197,    21'd100,  13'd7,    13'd0,    1'b0, 1'b1};
    tbl[2] = '{13'd1029, 13'd1124, 21'd9221,    21'd1124, 13'd1024, 13'd1024, 1'b0, 1'b1};
    tbl[3] = '{13'd5,    13'd100,  21'd8197,    21'd100,  13'd7168, 13'd7168, 1'b0, 1'b1};
    tbl[4] = '{13'd4101, 13'd100,  21'd8197,    21'd100,  13'd0,    13'd0,    1'b1, 1'b1};
    tbl[5] = '{13'd3,    13'd100,  21'd3,       21'd100,  13'd0,    13'd0,    1'b0, 1'b0};
    tbl[6] = '{13'd8190, 13'd100,  21'd2097150, 21'd100,  13'd8187, 13'd0,    1'b0, 1'b0};

    bus.frame_done   = 1'b0;
    bus.enc1_data    = '0;
    bus.enc2_data    = '0;
    bus.clear_faults = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Reference frame from the verification list, then wraps and limits.
    begin
      run_frame(13'd100, 13'd8000, lat);
      chk("first latency", 32'(lat), 3);
      chk("first enc1_pos", 32'(bus.enc1_pos), 100);
      chk("first enc2_pos", 32'(bus.enc2_pos), 8000);
      chk("first deltas", 32'({bus.enc1_delta, bus.enc2_delta}), 0);
      chk("first faults", 32'({bus.enc1_fault, bus.enc2_fault, bus.overrun}), 0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end

    for (int i = 0; i < 5; i++) apply_row(i);

    // Clear alone drops both sticky faults.
    @(negedge clk);
    bus.clear_faults = 1'b1;
    @(negedge clk);
    bus.clear_faults = 1'b0;
    chk("clear enc1_fault", 32'(bus.enc1_fault), 0);
    chk("clear enc2_fault", 32'(bus.enc2_fault), 0);

    // Clear in the same cycle as a new enc2 fault: the set wins.
    @(negedge clk);
    bus.frame_done = 1'b1;
    bus.enc1_data  = 13'd10;
    bus.enc2_data  = 13'd2000;
    @(negedge clk);
    bus.frame_done = 1'b0;
    @(negedge clk);
    bus.clear_faults = 1'b1;
    @(negedge clk);
    bus.clear_faults = 1'b0;
    chk("setwin pos_valid", 32'(bus.pos_valid), 1);
    chk("setwin enc2_fault", 32'(bus.enc2_fault), 1);
    chk("setwin enc1_fault", 32'(bus.enc1_fault), 0);
    chk("setwin enc1_pos", 32'(bus.enc1_pos), 8202);
    chk("setwin enc1_delta", 32'(bus.enc1_delta), 5);
    chk("setwin enc2_pos", 32'(bus.enc2_pos), 100);
    chk("setwin enc2_delta", 32'(bus.enc2_delta), 0);
    @(negedge clk);

    // Second frame_done during CH1 sets overrun and is otherwise ignored.
    @(negedge clk);
    bus.frame_done = 1'b1;
    bus.enc1_data  = 13'd20;
    bus.enc2_data  = 13'd150;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cnt += int'(bus.pos_valid);
      if (i == 0) begin
        bus.enc1_data = 13'd4000;
        bus.enc2_data = 13'd4000;
      end
      if (i == 1) bus.frame_done = 1'b0;
    end
    chk("overrun flag", 32'(bus.overrun), 1);
    chk("overrun pos_valid count", 32'(cnt), 1);
    chk("overrun enc1_pos", 32'(bus.enc1_pos), 8212);
    chk("overrun enc2_pos", 32'(bus.enc2_pos), 150);
    chk("overrun enc1_delta", 32'(bus.enc1_delta), 10);
    chk("overrun enc2_delta", 32'(bus.enc2_delta), 50);

    // Reset asserted while in CH2 clears everything and suppresses pos_valid.
    @(negedge clk);
    bus.frame_done = 1'b1;
    bus.enc1_data  = 13'd30;
    bus.enc2_data  = 13'd160;
    @(negedge clk);
    bus.frame_done = 1'b0;
    @(negedge clk);
    chk("midreset in CH2 busy", 32'(bus.busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("midreset");
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cnt += int'(bus.pos_valid);
    end
    chk("midreset no pos_valid", 32'(cnt), 0);

    // First frame after reset re-primes, then a backward wrap below zero.
    for (int i = 5; i < 7; i++) apply_row(i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/encoder_tracker.md
ENCODER_TRACKER -- requirements
Module: encoder_tracker

Interface
REQ-001 SHALL have parameter MAX_STEP, default 1024, the largest accepted per-frame step magnitude in counts (legal range 1..4095).
REQ-002 SHALL have parameter TURN_BITS, default 8, the width of the multi-turn extension above the 13-bit single-turn value.
REQ-003 SHALL have port CLK_10MHZ  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port RESET_N  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port frame_done  input  1  one-cycle pulse marking that enc1_data/enc2_data hold a freshly completed 13-bit encoder frame.
REQ-006 SHALL have ports enc1_data, enc2_data  input  13 each  raw single-turn absolute positions from the encoder SPI reader.
REQ-007 SHALL have port clear_faults  input  1  clears sticky flags.
REQ-008 SHALL have ports enc1_pos, enc2_pos  output  TURN_BITS+13 each  accumulated multi-turn positions.
REQ-009 SHALL have ports enc1_delta, enc2_delta  output  13 each  signed step applied in the last processed frame.
REQ-010 SHALL have port pos_valid  output  1  one-cycle pulse when positions/deltas have been updated.
REQ-011 SHALL have ports enc1_fault, enc2_fault, overrun  output  1 each  sticky error flags.
REQ-012 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, CH1, CH2, DONE; IDLE->CH1 on frame_done, CH1->CH2, CH2->DONE, DONE->IDLE unconditionally.
REQ-014 SHALL capture enc1_data and enc2_data into internal registers on the IDLE cycle in which frame_done is high; later input changes SHALL not affect the frame.
REQ-015 SHALL update channel 1 in CH1 and channel 2 in CH2 through a single shared arithmetic path.
REQ-016 SHALL assert pos_valid for exactly the DONE cycle, so it is high in the 3rd cycle after the frame_done cycle (frame_done at edge N -> pos_valid high between edges N+3 and N+4).
REQ-017 SHALL compute the step d = (raw - prev) mod 8192, interpreted as signed 13-bit (range -4096..+4095), so crossing 8191->0 yields a positive step and 0->8191 yields a negative step.
REQ-018 SHALL accept a step when |d| <= MAX_STEP: pos <= pos + sign-extended d (modulo 2^(TURN_BITS+13)), delta <= d, prev <= raw.
REQ-019 SHALL reject a step when |d| > MAX_STEP (d = -4096 is always rejected): pos and prev unchanged, delta <= 0, channel fault flag set.
REQ-020 SHALL, for the first processed frame after reset, load pos <= zero-extended raw, prev <= raw, delta <= 0, with no plausibility check; one shared "primed" flag governs both channels.
REQ-021 SHALL ignore frame_done while busy, set overrun, and leave the in-flight frame undisturbed.
REQ-022 SHALL clear enc1_fault, enc2_fault and overrun on clear_faults; a set event in the same cycle SHALL win over the clear.
REQ-023 SHALL hold pos, delta and flags stable between updates.

Reset
REQ-024 SHALL, on a clock edge with RESET_N low, force state IDLE, all outputs to 0, prev registers to 0 and primed to 0, regardless of state, including mid-frame.
REQ-025 SHALL not assert pos_valid for a frame interrupted by reset, and SHALL treat the first frame after reset release per REQ-020.

Structure
REQ-026 SHALL take ENC_BITS (13), the state encoding and the default MAX_STEP from a shared package encoder_pkg, which the SPI reader also uses.
REQ-027 SHALL place the wrap-aware step and plausibility arithmetic in one sub-module encoder_step_calc (inputs raw, prev, max_step; outputs d, accept), instantiated once and muxed between channels.

Verification
REQ-028 SHALL test: reset, frame enc1=100, enc2=8000 -> pos_valid 3 cycles later, enc1_pos=100, enc2_pos=8000, deltas 0, no faults.
REQ-029 SHALL test forward wrap: prev enc1=8190, frame enc1=5 -> enc1_delta=+7, enc1_pos=8197.
REQ-030 SHALL test backward wrap below zero: pos=3, frame enc1=8190 -> enc1_delta=-5, enc1_pos=2097150 (2^21-2).
REQ-031 SHALL test jump rejection: prev enc2=100, frame enc2=2000 -> enc2_pos unchanged, enc2_delta=0, enc2_fault=1; same-cycle clear_faults and new fault -> flag stays 1; step exactly 1024 -> accepted.
REQ-032 SHALL test overrun and reset: frame_done in CH1 -> overrun=1, one pos_valid only; RESET_N low during CH2 -> next cycle all outputs 0, no pos_valid.
